// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the stall controller and the pipeline.
// The controller sits on the slave side; the pipeline drives the master side.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [3:0]       id_op1;
  logic [3:0]       id_op2;
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [3:0]       ex_funct;
  logic [3:0]       ex_dest;
  logic             branch_taken;
  logic             mdu_done;
  logic             clr_stats;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mdu_start;
  logic             mdu_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_op1, id_op2,
    output ex_valid, ex_opcode, ex_funct, ex_dest,
    output branch_taken, mdu_done, clr_stats,
    input  pc_write, ifid_write, ifid_flush,
    input  idex_write, idex_bubble, exmem_bubble,
    input  mdu_start, mdu_timeout_err, stall_cycles
  );

  modport slave (
    input  id_valid, id_op1, id_op2,
    input  ex_valid, ex_opcode, ex_funct, ex_dest,
    input  branch_taken, mdu_done, clr_stats,
    output pc_write, ifid_write, ifid_flush,
    output idex_write, idex_bubble, exmem_bubble,
    output mdu_start, mdu_timeout_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: load-use bubble, MDU freeze with timeout,
// taken-branch IF/ID flush, and a saturating stall-cycle counter.
module pipeline_stall_controller #(
  parameter logic [3:0] LOAD_OPCODE  = 4'b1000,
  parameter logic [3:0] RTYPE_OPCODE = 4'b0001,
  parameter logic [3:0] MUL_FUNCT    = 4'b0100,
  parameter logic [3:0] DIV_FUNCT    = 4'b0101,
  parameter int         MDU_TIMEOUT  = 32,
  parameter int         CNT_W        = 8
) (
  input logic clk,
  input logic rst,
  pipeline_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_BUBBLE,
    MDU_WAIT
  } state_t;

  localparam int WW = $clog2(MDU_TIMEOUT) + 1;
  localparam logic [WW-1:0] WLAST = WW'(MDU_TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;
  logic [WW-1:0]    wcnt;
  logic [WW-1:0]    wcnt_nx;
  logic             timeout_hit;
  logic             err;
  logic [CNT_W-1:0] cnt;

  logic mdu_op;
  logic load_use;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  logic exmem_bubble;
  logic mdu_start;

  assign mdu_op = bus.ex_valid
    && bus.ex_opcode == RTYPE_OPCODE
    && (bus.ex_funct == MUL_FUNCT
     || bus.ex_funct == DIV_FUNCT);

  assign load_use = bus.ex_valid && bus.id_valid
    && bus.ex_opcode == LOAD_OPCODE
    && (bus.id_op1 == bus.ex_dest
     || bus.id_op2 == bus.ex_dest);

  always_comb begin
    state_nx     = state;
    wcnt_nx      = wcnt;
    timeout_hit  = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mdu_start    = 1'b0;
    if (rst) begin
      state_nx     = RUN;
      wcnt_nx      = '0;
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mdu_op) begin
            mdu_start    = 1'b1;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            wcnt_nx      = '0;
            state_nx     = MDU_WAIT;
          end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nx    = LOAD_BUBBLE;
          end else begin
            ifid_flush = bus.branch_taken;
          end
        end
        LOAD_BUBBLE: begin
          ifid_flush = bus.branch_taken;
          state_nx   = RUN;
        end
        MDU_WAIT: begin
          // done releases in this cycle so the result enters EX/MEM
          if (bus.mdu_done) begin
            state_nx = RUN;
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            wcnt_nx      = wcnt + 1'b1;
            if (wcnt == WLAST) begin
              timeout_hit = 1'b1;
              state_nx    = RUN;
            end
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt  <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (timeout_hit) err <= 1'b1;
      if (bus.clr_stats) cnt <= '0;
      else if (!pc_write && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.pc_write        = pc_write;
  assign bus.ifid_write      = ifid_write;
  assign bus.ifid_flush      = ifid_flush;
  assign bus.idex_write      = idex_write;
  assign bus.idex_bubble     = idex_bubble;
  assign bus.exmem_bubble    = exmem_bubble;
  assign bus.mdu_start       = mdu_start;
  assign bus.mdu_timeout_err = err;
  assign bus.stall_cycles    = cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed and random stimulus for the stall controller, checked
// against a cycle-level reference model of the hazard rules.
module tb_pipeline_stall_controller;

  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_stall_controller_if #(.CNT_W(8)) bus ();

  pipeline_stall_controller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: age of current MDU op (0 = none), pending load bubble
  int   m_age = 0;
  bit   m_lb = 0;
  bit   m_err = 0;
  int   m_cnt = 0;
  bit   m_known = 0;

  localparam logic [6:0] DEF = 7'b1101000;
  localparam logic [6:0] FLS = 7'b0010000;
  localparam logic [6:0] FRZ = 7'b0000010;
  localparam logic [6:0] STR = 7'b0000011;
  localparam logic [6:0] LDU = 7'b0001100;
  localparam logic [6:0] RST = 7'b0011110;

  function automatic bit is_mop();
    return bus.ex_valid && bus.ex_opcode == 4'b0001
      && (bus.ex_funct == 4'b0100 || bus.ex_funct == 4'b0101);
  endfunction

  function automatic bit is_lu();
    return bus.ex_valid && bus.id_valid
      && bus.ex_opcode == 4'b1000
      && (bus.id_op1 == bus.ex_dest
       || bus.id_op2 == bus.ex_dest);
  endfunction

  function automatic logic [6:0] exp_ctl();
    if (rst) return RST;
    if (m_age > 0) return bus.mdu_done ? DEF : FRZ;
    if (m_lb) return bus.branch_taken ? (DEF | FLS) : DEF;
    if (is_mop()) return STR;
    if (is_lu()) return LDU;
    return bus.branch_taken ? (DEF | FLS) : DEF;
  endfunction

  function automatic logic [6:0] act_ctl();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
            bus.idex_write, bus.idex_bubble,
            bus.exmem_bubble, bus.mdu_start};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [6:0] e;
    bit stalled;
    e = exp_ctl();
    stalled = !e[6];
    if (rst) begin
      m_age = 0; m_lb = 0; m_err = 0; m_cnt = 0;
      m_known = 1;
      return;
    end
    if (bus.clr_stats) m_cnt = 0;
    else if (stalled && m_cnt < 255) m_cnt++;
    if (m_age > 0) begin
      if (bus.mdu_done) m_age = 0;
      else if (m_age == TO) begin
        m_age = 0; m_err = 1;
      end else m_age++;
    end else if (m_lb) m_lb = 0;
    else if (is_mop()) m_age = 1;
    else if (is_lu()) m_lb = 1;
  endtask

  task automatic cycle();
    #1;
    chk("ctl", 32'(act_ctl()), 32'(exp_ctl()));
    if (m_known) begin
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_cnt));
      chk("timeout_err", 32'(bus.mdu_timeout_err), 32'(m_err));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_op1 = 4'd0; bus.id_op2 = 4'd0;
    bus.ex_valid = 0; bus.ex_opcode = 4'd0;
    bus.ex_funct = 4'd0; bus.ex_dest = 4'd0;
    bus.branch_taken = 0; bus.mdu_done = 0;
    bus.clr_stats = 0;
  endtask

  task automatic set_load();
    bus.ex_valid = 1; bus.ex_opcode = 4'b1000; bus.ex_dest = 4'd3;
    bus.id_valid = 1; bus.id_op1 = 4'd5; bus.id_op2 = 4'd3;
  endtask

  task automatic set_mdu();
    bus.ex_valid = 1; bus.ex_opcode = 4'b0001;
    bus.ex_funct = 4'b0101; bus.ex_dest = 4'd7;
  endtask

  task automatic clear_stats();
    idle(); bus.clr_stats = 1; cycle(); bus.clr_stats = 0;
  endtask

  task automatic rand_inputs();
    bus.id_valid = 1'($urandom_range(0, 1));
    bus.id_op1 = 4'($urandom_range(0, 3));
    bus.id_op2 = 4'($urandom_range(0, 3));
    bus.ex_valid = 1'($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 2))
      0: bus.ex_opcode = 4'b1000;
      1: bus.ex_opcode = 4'b0001;
      default: bus.ex_opcode = 4'($urandom_range(0, 15));
    endcase
    bus.ex_funct = 4'($urandom_range(3, 6));
    bus.ex_dest = 4'($urandom_range(0, 3));
    bus.branch_taken = 1'($urandom_range(0, 2) == 0);
    bus.mdu_done = 1'($urandom_range(0, 9) == 0);
    bus.clr_stats = 1'($urandom_range(0, 49) == 0);
    rst = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    cycle();
    chk("reset_cnt", 32'(bus.stall_cycles), 32'd0);

    // load-use: one stall, then masked with inputs held
    set_load();
    cycle();
    cycle();
    idle();
    #1 chk("ld_cnt", 32'(bus.stall_cycles), 32'd1);
    cycle();

    // MDU with done five cycles after start
    clear_stats();
    set_mdu();
    cycle();
    bus.ex_valid = 0;
    repeat (4) cycle();
    bus.mdu_done = 1;
    #1 chk("mdu_rel", 32'(bus.pc_write), 32'd1);
    cycle();
    idle();
    #1 chk("mdu_cnt", 32'(bus.stall_cycles), 32'd5);
    cycle();

    // MDU timeout
    clear_stats();
    set_mdu();
    cycle();
    bus.ex_valid = 0;
    repeat (TO) cycle();
    idle();
    #1 chk("to_pc", 32'(bus.pc_write), 32'd1);
    chk("to_err", 32'(bus.mdu_timeout_err), 32'd1);
    chk("to_cnt", 32'(bus.stall_cycles), 32'd33);
    cycle();

    // load-use together with a held taken branch
    set_load();
    bus.branch_taken = 1;
    #1 chk("lb_nofl", 32'(bus.ifid_flush), 32'd0);
    cycle();
    #1 chk("lb_flush", 32'(bus.ifid_flush), 32'd1);
    cycle();
    idle();
    cycle();

    // counter saturation and clear
    clear_stats();
    set_load();
    repeat (1200) cycle();
    idle();
    #1 chk("sat_cnt", 32'(bus.stall_cycles), 32'd255);
    chk("sat_err", 32'(bus.mdu_timeout_err), 32'd1);
    bus.clr_stats = 1;
    cycle();
    bus.clr_stats = 0;
    #1 chk("clr_cnt", 32'(bus.stall_cycles), 32'd0);
    cycle();

    // randomized traffic
    repeat (3000) begin
      rand_inputs();
      cycle();
    end
    rst = 1;
    idle();
    cycle();
    rst = 0;
    cycle();
    chk("end_err", 32'(bus.mdu_timeout_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
